// File: rtl/aes_rk_pkg.sv
// Shared types for the AES round-key store: controller states, key and index types.
package aes_rk_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    READY
  } rk_state_e;

  typedef logic [127:0] round_key_t;
  typedef logic [3:0]   rk_idx_t;

  localparam int RK_DEPTH = 16;

endpackage

// File: rtl/round_key_ram_ctrl.sv
// Round-key store sequencer: loads a key table into the hi/lo RAMs and serves reads once it is complete.
// Optional RK_REVERSE_EN adds rk_rev, which mirrors the physical read address for decryption order.
module round_key_ram_ctrl
  import aes_rk_pkg::*;
#(
  parameter int NUM_KEYS = 11,
  parameter int ADDR_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              kx_start,
  input  logic              kx_valid,
  output logic              kx_ready,
  input  round_key_t        kx_key,
  input  logic              rk_req,
  input  logic [ADDR_W-1:0] rk_idx,
`ifdef RK_REVERSE_EN
  input  logic              rk_rev,
`endif
  output logic              rk_gnt,
  output logic              rk_valid,
  output round_key_t        rk_key,
  output logic              rk_err,
  output logic              keys_valid,
  output logic              ram_wr,
  output logic [ADDR_W-1:0] ram_wr_addr,
  output round_key_t        ram_wr_data,
  output logic              ram_rd,
  output logic [ADDR_W-1:0] ram_rd_addr,
  input  round_key_t        ram_rd_data
);

  localparam int unsigned       KEYS_USED  = (NUM_KEYS > RK_DEPTH) ? RK_DEPTH : NUM_KEYS;
  localparam logic [ADDR_W:0]   NUM_KEYS_W = KEYS_USED[ADDR_W:0];
  localparam logic [ADDR_W-1:0] LAST_IDX   = ADDR_W'(KEYS_USED - 1);

  rk_state_e         state_q;
  logic [ADDR_W-1:0] wptr_q;
  logic              keys_valid_q;
  logic              rsp_valid_q;
  logic              rsp_err_q;
  round_key_t        rk_key_q;
  round_key_t        rk_key_d;
  logic              kx_accept;
  logic              in_range;
  rk_idx_t           phys_idx;

  // NOTE: every signal assigned here gets a value on every path, so no latch is inferred.
  always_comb begin
    kx_ready    = (state_q == LOAD) && !kx_start;
    kx_accept   = kx_ready && kx_valid;
    in_range    = {1'b0, rk_idx} < NUM_KEYS_W;
    rk_gnt      = (state_q == READY) && rk_req && !kx_start;
    phys_idx    = rk_idx;
`ifdef RK_REVERSE_EN
    if (rk_rev) phys_idx = LAST_IDX - rk_idx;
`endif
    ram_wr      = kx_accept;
    ram_wr_addr = wptr_q;
    ram_wr_data = kx_key;
    ram_rd      = rk_gnt && in_range;
    ram_rd_addr = phys_idx;
  end

  // kx_start restarts a load from any state and always overrides the current table.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      wptr_q       <= '0;
      keys_valid_q <= 1'b0;
    end else if (kx_start) begin
      state_q      <= LOAD;
      wptr_q       <= '0;
      keys_valid_q <= 1'b0;
    end else begin
      case (state_q)
        LOAD: begin
          if (kx_accept) begin
            wptr_q <= wptr_q + 1'b1;
            if (wptr_q == LAST_IDX) begin
              state_q      <= READY;
              keys_valid_q <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Response stage: RAM data arrives one cycle after the grant and is presented directly.
  always_comb begin
    rk_key_d = rk_key_q;
    if (rsp_valid_q) rk_key_d = rsp_err_q ? '0 : ram_rd_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rk_key_q    <= '0;
    end else begin
      rsp_valid_q <= rk_gnt;
      rsp_err_q   <= rk_gnt && !in_range;
      rk_key_q    <= rk_key_d;
    end
  end

  assign rk_valid   = rsp_valid_q;
  assign rk_err     = rsp_err_q;
  assign rk_key     = rk_key_d;
  assign keys_valid = keys_valid_q;

endmodule

// File: tb/tb_round_key_ram_ctrl.sv
// Self-checking bench for round_key_ram_ctrl with a behavioural {hi,lo} RAM and a response scoreboard.
module tb_round_key_ram_ctrl;
  import aes_rk_pkg::*;

  localparam int NK = 11;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       kx_start, kx_valid, kx_ready;
  round_key_t kx_key;
  logic       rk_req;
  logic [3:0] rk_idx;
  logic       rk_rev_tb;
  logic       rk_gnt, rk_valid, rk_err, keys_valid;
  round_key_t rk_key;
  logic       ram_wr, ram_rd;
  logic [3:0] ram_wr_addr, ram_rd_addr;
  round_key_t ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  round_key_ram_ctrl #(.NUM_KEYS(NK), .ADDR_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .kx_start   (kx_start),
    .kx_valid   (kx_valid),
    .kx_ready   (kx_ready),
    .kx_key     (kx_key),
    .rk_req     (rk_req),
    .rk_idx     (rk_idx),
`ifdef RK_REVERSE_EN
    .rk_rev     (rk_rev_tb),
`endif
    .rk_gnt     (rk_gnt),
    .rk_valid   (rk_valid),
    .rk_key     (rk_key),
    .rk_err     (rk_err),
    .keys_valid (keys_valid),
    .ram_wr     (ram_wr),
    .ram_wr_addr(ram_wr_addr),
    .ram_wr_data(ram_wr_data),
    .ram_rd     (ram_rd),
    .ram_rd_addr(ram_rd_addr),
    .ram_rd_data(ram_rd_data)
  );

  // The two 16x64 RAMs of the parent, modelled as one 128-bit wide array.
  round_key_t mem [16];
  always @(posedge clk) begin
    if (ram_wr) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_rd) ram_rd_data <= mem[ram_rd_addr];
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic round_key_t key_a(input int i);
    logic [3:0] n;
    n = 4'(i);
    return {32{n}};
  endfunction

  function automatic round_key_t key_b(input int i);
    logic [7:0] n;
    n = 8'(8'hA0 + i);
    return {16{n}};
  endfunction

  typedef struct {
    logic       err;
    round_key_t key;
  } rsp_t;

  round_key_t exp_tab [NK];
  rsp_t       sb [$];
  rsp_t       mon_e;
  int         mon_li;

  // Retire responses first, then record the grant made in this same cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rk_valid) begin
        if (sb.size() == 0) check("rsp_unexpected", 128'd1, 128'd0);
        else begin
          mon_e = sb.pop_front();
          check("rk_key", rk_key, mon_e.key);
          check("rk_err", {127'd0, rk_err}, {127'd0, mon_e.err});
        end
      end
      if (rk_gnt) begin
        mon_li    = int'(rk_idx);
        mon_e.err = (mon_li >= NK);
        mon_e.key = '0;
        if (mon_li < NK) mon_e.key = exp_tab[rk_rev_tb ? (NK - 1 - mon_li) : mon_li];
        sb.push_back(mon_e);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start_load();
    kx_start = 1'b1;
    kx_valid = 1'b1;
    kx_key   = '1;
    @(negedge clk);
    check("start_kx_ready", {127'd0, kx_ready}, 128'd0);
    check("start_no_wr", {127'd0, ram_wr}, 128'd0);
    check("start_no_gnt", {127'd0, rk_gnt}, 128'd0);
    cyc();
    kx_start = 1'b0;
    kx_valid = 1'b0;
  endtask

  task automatic write_keys(input int n, input bit use_b);
    for (int i = 0; i < n; i++) begin
      kx_valid = 1'b1;
      kx_key   = use_b ? key_b(i) : key_a(i);
      @(negedge clk);
      check("wr_en", {127'd0, ram_wr}, 128'd1);
      check("wr_addr", {124'd0, ram_wr_addr}, 128'(i));
      check("wr_data", ram_wr_data, kx_key);
      check("load_kv_low", {127'd0, keys_valid}, 128'd0);
      check("load_no_gnt", {127'd0, rk_gnt}, 128'd0);
      cyc();
    end
    kx_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; kx_start = 1'b0; kx_valid = 1'b0; kx_key = '0;
    rk_req = 1'b0; rk_idx = '0; rk_rev_tb = 1'b0; ram_rd_data = '0;
    for (int i = 0; i < NK; i++) exp_tab[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_kv", {127'd0, keys_valid}, 128'd0);
    check("rst_kx_ready", {127'd0, kx_ready}, 128'd0);
    check("rst_gnt", {127'd0, rk_gnt}, 128'd0);
    check("rst_rk_valid", {127'd0, rk_valid}, 128'd0);
    check("rst_rk_err", {127'd0, rk_err}, 128'd0);
    check("rst_ram_wr", {127'd0, ram_wr}, 128'd0);
    check("rst_ram_rd", {127'd0, ram_rd}, 128'd0);
    check("rst_rk_key", rk_key, 128'd0);
    rst_n = 1'b1;
    cyc();

    // Full load of table A.
    start_load();
    write_keys(NK, 1'b0);
    for (int i = 0; i < NK; i++) exp_tab[i] = key_a(i);
    @(negedge clk);
    check("load_done_kv", {127'd0, keys_valid}, 128'd1);
    check("ready_kx_ready", {127'd0, kx_ready}, 128'd0);
    check("ready_kx_ignored", {127'd0, ram_wr}, 128'd0);
    cyc();

    // Back-to-back in-range reads.
    for (int i = 0; i < NK; i++) begin
      rk_req = 1'b1;
      rk_idx = 4'(i);
      @(negedge clk);
      check("rd_gnt", {127'd0, rk_gnt}, 128'd1);
      check("rd_ram_rd", {127'd0, ram_rd}, 128'd1);
      check("rd_addr", {124'd0, ram_rd_addr}, 128'(i));
      if (i > 0) check("rd_no_bubble", {127'd0, rk_valid}, 128'd1);
      cyc();
    end
    rk_req = 1'b0;
    @(negedge clk);
    check("rd_last_valid", {127'd0, rk_valid}, 128'd1);
    cyc();
    @(negedge clk);
    check("rd_idle_valid", {127'd0, rk_valid}, 128'd0);
    check("rk_key_hold", rk_key, key_a(NK - 1));
    cyc();

    // Out-of-range indices, including the first one past the table.
    for (int k = 0; k < 3; k++) begin
      rk_req = 1'b1;
      rk_idx = (k == 0) ? 4'd11 : (k == 1) ? 4'd12 : 4'd15;
      @(negedge clk);
      check("oor_gnt", {127'd0, rk_gnt}, 128'd1);
      check("oor_no_ram_rd", {127'd0, ram_rd}, 128'd0);
      cyc();
    end
    rk_req = 1'b0;
    cyc();
    @(negedge clk);
    check("oor_key_hold", rk_key, 128'd0);
    cyc();

    // Restart mid-load with a request held; kx_start in READY also collides with rk_req.
    rk_req = 1'b1;
    rk_idx = 4'd2;
    start_load();
    write_keys(5, 1'b1);
    start_load();
    write_keys(NK, 1'b1);
    for (int i = 0; i < NK; i++) exp_tab[i] = key_b(i);
    @(negedge clk);
    check("reload_kv", {127'd0, keys_valid}, 128'd1);
    check("held_req_gnt", {127'd0, rk_gnt}, 128'd1);
    cyc();
    rk_req = 1'b0;
    cyc();

    // kx_start right after a grant: the pending response still returns old table data.
    rk_req = 1'b1;
    rk_idx = 4'd4;
    @(negedge clk);
    check("late_gnt", {127'd0, rk_gnt}, 128'd1);
    cyc();
    rk_req = 1'b0;
    kx_start = 1'b1;
    @(negedge clk);
    check("late_rsp_valid", {127'd0, rk_valid}, 128'd1);
    cyc();
    kx_start = 1'b0;
    @(negedge clk);
    check("late_kv_drop", {127'd0, keys_valid}, 128'd0);
    check("late_no_rsp", {127'd0, rk_valid}, 128'd0);
    cyc();
    write_keys(NK, 1'b0);
    for (int i = 0; i < NK; i++) exp_tab[i] = key_a(i);
    cyc();

`ifdef RK_REVERSE_EN
    rk_rev_tb = 1'b1;
    for (int k = 0; k < 3; k++) begin
      rk_req = 1'b1;
      rk_idx = (k == 0) ? 4'd0 : (k == 1) ? 4'd10 : 4'd11;
      @(negedge clk);
      check("rev_gnt", {127'd0, rk_gnt}, 128'd1);
      if (k == 0) check("rev_addr0", {124'd0, ram_rd_addr}, 128'd10);
      if (k == 1) check("rev_addr10", {124'd0, ram_rd_addr}, 128'd0);
      if (k == 2) check("rev_oor_no_rd", {127'd0, ram_rd}, 128'd0);
      cyc();
    end
    rk_req = 1'b0;
    cyc();
    rk_rev_tb = 1'b0;
`endif

    repeat (3) cyc();
    check("sb_drained", 128'(sb.size()), 128'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/round_key_ram_ctrl.md
Name: round_key_ram_ctrl

Overview:
- Sequences the round-key store: two 16x64 RAMs (hi/lo halves) holding up to 16 128-bit round keys.
- Shares the store between the key-expansion writer and the cipher-round reader.
- Owns table validity, so a reader never sees a partially loaded key table.
- Sits between key expansion and the round datapath in the AES core; the RAM instances live in the parent.

Parameters:
- NUM_KEYS, 11, round keys per table (11/13/15 for AES-128/192/256); legal range 1..16.
- ADDR_W, 4, RAM address width; fixed at 4 for the 16-deep RAMs.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- kx_start  in  1  pulse: begin a new table load; invalidates the current table.
- kx_valid  in  1  writer has a key on kx_key.
- kx_ready  out  1  controller accepts kx_key this cycle.
- kx_key  in  128  round key, written in index order 0..NUM_KEYS-1.
- rk_req  in  1  reader requests a key.
- rk_idx  in  4  requested round index.
- rk_gnt  out  1  request accepted this cycle.
- rk_valid  out  1  rk_key/rk_err valid; 1-cycle pulse.
- rk_key  out  128  round key read back.
- rk_err  out  1  accepted index was >= NUM_KEYS.
- keys_valid  out  1  full table loaded.
- ram_wr  out  1  RAM write enable, shared by both halves.
- ram_wr_addr  out  4  RAM write address.
- ram_wr_data  out  128  [127:64] to the hi RAM, [63:0] to the lo RAM.
- ram_rd  out  1  RAM read-address capture enable.
- ram_rd_addr  out  4  RAM read address.
- ram_rd_data  in  128  {hi, lo} RAM read data; valid the cycle after ram_rd.

Behaviour:
- Reset: state IDLE, wptr=0; keys_valid, kx_ready, rk_gnt, rk_valid, rk_err, ram_wr, ram_rd = 0; rk_key = 0.
- States: IDLE, LOAD, READY.
  - IDLE -> LOAD on kx_start.
  - LOAD -> READY when the NUM_KEYS-th key is accepted.
  - Any state -> LOAD on kx_start.
- LOAD:
  - kx_ready=1.
  - On kx_valid&kx_ready, same cycle: ram_wr=1, ram_wr_addr=wptr, ram_wr_data=kx_key; wptr increments.
  - wptr is cleared on kx_start.
  - On the last accept: keys_valid=1 and state=READY in the next cycle; kx_ready=0 from that cycle.
- kx_start cycle: kx_ready=0, no write occurs, keys_valid drops next cycle.
- READY:
  - rk_req gives rk_gnt=1 combinationally, with ram_rd=1 and ram_rd_addr=rk_idx.
  - The next cycle gives rk_valid=1 and rk_key=ram_rd_data.
  - Back-to-back requests are accepted every cycle, so throughput is 1/cycle at latency 1.
- Out-of-range index (rk_idx >= NUM_KEYS): gnt=1, ram_rd=0; next cycle rk_valid=1, rk_err=1, rk_key=0.
- rk_req in IDLE or LOAD: rk_gnt=0; the reader holds the request.
- kx_start and rk_req in the same cycle: kx_start wins, rk_gnt=0.
- kx_start one cycle after a grant: the pending response still issues, with data from the old table.
- rk_key holds its last value when rk_valid=0.
- kx_valid outside LOAD: ignored.
- Async reset mid-load: table invalid; RAM contents are don't-care.

Optional Feature:
- Macro: RK_REVERSE_EN.
- When defined:
  - Adds input port rk_rev (1 bit).
  - A grant with rk_rev=1 reads physical address NUM_KEYS-1-rk_idx, giving decryption key order.
  - The range check uses the logical rk_idx.
- When undefined: the port is absent and the address is always rk_idx.

Decomposition:
- Package aes_rk_pkg:
  - rk_state_e {IDLE, LOAD, READY}.
  - round_key_t (logic [127:0]).
  - RK_DEPTH=16.
  - rk_idx_t (logic [3:0]).
- No sub-module. The two ram_16x64 instances are wired in the parent; the read-response register stays inline.

Test Plan:
- Reset, then kx_start and 11 keys K[i]=128'h{i repeated}, one per cycle -> 11 ram_wr pulses at addresses 0..10; keys_valid=1 the cycle after the 11th accept.
- READY with rk_idx=0..10 on consecutive cycles -> rk_gnt=1 each cycle; rk_valid and rk_key=K[i] one cycle later with no bubbles.
- rk_req, rk_idx=12 -> rk_gnt=1, ram_rd=0; next cycle rk_valid=1, rk_err=1, rk_key=0.
- kx_start after 5 keys are accepted, then a full load of 11 new keys -> writes restart at address 0; keys_valid stays 0 until the 11th new key; rk_req is held un-granted throughout.
- kx_start in the same cycle as rk_req in READY -> rk_gnt=0, keys_valid=0 next cycle, no rk_valid.
- RK_REVERSE_EN defined, rk_rev=1, rk_idx=0 -> ram_rd_addr=10, rk_key=K[10].
